// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment driver with frame-aligned staging.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZB_EN.
module seven_seg_scanner #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [6:0]            LED,
  output logic [DIGITS-1:0]     an,
  output logic                  dp_n,
  output logic                  pending,
  output logic                  frame_tick
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]  div;
  logic [IDX_W-1:0]  idx;
  logic [VAL_W-1:0]  stage_value, active_value;
  logic [DIGITS-1:0] stage_dp, stage_blank;
  logic [DIGITS-1:0] active_dp, active_blank;

  logic              div_tc_c;
  logic              boundary_c;
  logic [DIGITS-1:0] lzb_mask_c;
  logic [DIGITS-1:0] sel_c;
  logic [3:0]        nib_c;
  logic              dp_bit_c;
  logic              blank_bit_c;
  logic [6:0]        led_c;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  // Scan timing: terminal count of the divider and end-of-frame detection.
  always_comb begin
    div_tc_c   = (div == DIV_LAST);
    boundary_c = div_tc_c && (idx == IDX_LAST);
  end

  // Leading-zero mask derived from the staged word so it is ready at commit.
`ifdef SEVSEG_LZB_EN
  logic zero_run_c;
  always_comb begin
    lzb_mask_c = '0;
    zero_run_c = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      zero_run_c    = zero_run_c && (stage_value[4*k +: 4] == 4'h0);
      lzb_mask_c[k] = zero_run_c;
    end
  end
`else
  always_comb begin
    lzb_mask_c = '0;
  end
`endif

  // Per-digit decode of the active registers for the current scan index.
  always_comb begin
    sel_c       = DIGITS'(1) << idx;
    nib_c       = 4'(active_value >> {idx, 2'b00});
    dp_bit_c    = |(active_dp & sel_c);
    blank_bit_c = |(active_blank & sel_c);
    led_c       = blank_bit_c ? 7'b1111111 : glyph(nib_c);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div          <= '0;
      idx          <= '0;
      stage_value  <= '0;
      stage_dp     <= '0;
      stage_blank  <= '0;
      active_value <= '0;
      active_dp    <= '0;
      active_blank <= '0;
      pending      <= 1'b0;
      frame_tick   <= 1'b0;
      LED          <= 7'b1111111;
      an           <= '1;
      dp_n         <= 1'b1;
    end else begin
      div <= div_tc_c ? '0 : div + DIV_W'(1);
      if (div_tc_c) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end

      // Commit reads the stage before any coincident load overwrites it.
      if (boundary_c && pending) begin
        active_value <= stage_value;
        active_dp    <= stage_dp;
        active_blank <= stage_blank | lzb_mask_c;
      end

      if (load) begin
        stage_value <= value;
        stage_dp    <= dp_in;
        stage_blank <= blank_in;
        pending     <= 1'b1;
      end else if (boundary_c) begin
        pending <= 1'b0;
      end

      frame_tick <= boundary_c;
      LED        <= led_c;
      an         <= ~sel_c;
      dp_n       <= ~dp_bit_c;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: cycle scoreboard fed by a time-based model plus table-driven frame checks.
`timescale 1ns/1ps
module tb_seven_seg_scanner;

  localparam int unsigned D     = 4;
  localparam int unsigned RD    = 4;
  localparam int unsigned FRAME = D * RD;
`ifdef SEVSEG_LZB_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010, G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100, G5 = 7'b0100100, G6 = 7'b0100000, G7 = 7'b0001111;
  localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0000100, GA = 7'b0001000, GB = 7'b1100000;
  localparam logic [6:0] GC = 7'b0110001, GD = 7'b1000010, GE = 7'b0110000, GF = 7'b0111000;
  localparam logic [6:0] BL = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in, blank_in;
  logic [6:0]  LED;
  logic [3:0]  an;
  logic        dp_n, pending, frame_tick;

  int checks = 0;
  int errors = 0;

  seven_seg_scanner #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .dp_in(dp_in),
    .blank_in(blank_in), .LED(LED), .an(an), .dp_n(dp_n), .pending(pending),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] led;
    logic [3:0] an;
    logic       dp_n;
    logic       pending;
    logic       frame_tick;
  } obs_t;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [27:0] leds;   // {digit3, digit2, digit1, digit0}
    logic [3:0]  dpn;
  } vec_t;

  obs_t       sb_q[$];
  logic [6:0] glyph_rom [16] = '{G0, G1, G2, G3, G4, G5, G6, G7, G8, G9, GA, GB, GC, GD, GE, GF};

  function automatic logic [3:0] lzb(input logic [15:0] v);
    logic [3:0] m;
    m = '0;
    for (int k = 1; k < 4; k++) m[k] = LZB_EN && ((v >> (4 * k)) == 16'h0);
    return m;
  endfunction

  // Reference model: position in the frame follows from cycles elapsed since reset release.
  int          t;
  logic [15:0] m_sval, m_aval;
  logic [3:0]  m_sdp, m_sblank, m_adp, m_ablank;
  logic        m_pend;

  always @(posedge clk) begin : model
    obs_t e;
    int   d;
    logic bnd;
    e = '0;
    if (!reset) begin
      t = 0; m_sval = '0; m_aval = '0; m_sdp = '0; m_sblank = '0;
      m_adp = '0; m_ablank = '0; m_pend = 1'b0;
      e.led = BL; e.an = 4'hF; e.dp_n = 1'b1;
    end else begin
      d   = (t / RD) % D;
      bnd = ((t % FRAME) == FRAME - 1);
      e.an         = 4'hF & ~(4'b0001 << d);
      e.led        = m_ablank[d] ? BL : glyph_rom[m_aval[4*d +: 4]];
      e.dp_n       = !m_adp[d];
      e.frame_tick = bnd;
      if (bnd && m_pend) begin
        m_aval = m_sval; m_adp = m_sdp; m_ablank = m_sblank | lzb(m_sval);
      end
      if (load) begin
        m_sval = value; m_sdp = dp_in; m_sblank = blank_in; m_pend = 1'b1;
      end else if (bnd) begin
        m_pend = 1'b0;
      end
      e.pending = m_pend;
      t++;
    end
    sb_q.push_back(e);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Advance one cycle and retire the scoreboard entry for the edge just taken.
  task automatic tick();
    obs_t e, a;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = {LED, an, dp_n, pending, frame_tick};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard at %0t: got led=%b an=%b dp_n=%b pend=%b ft=%b expected led=%b an=%b dp_n=%b pend=%b ft=%b",
                 $time, a.led, a.an, a.dp_n, a.pending, a.frame_tick,
                 e.led, e.an, e.dp_n, e.pending, e.frame_tick);
      end
    end
  endtask

  task automatic wait_ft();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME + 2 && !seen; i++) begin
      tick();
      seen = (frame_tick === 1'b1);
    end
    if (!seen) begin
      errors++;
      $display("FAIL frame_tick_timeout: got no pulse expected one within %0d cycles", 2 * FRAME + 2);
    end
  endtask

  // Called in a frame_tick cycle; checks the next full frame against hand-derived glyphs.
  task automatic check_frame(input string tag, input logic [27:0] leds, input logic [3:0] dpn,
                             input logic exp_pend);
    int k;
    for (int c = 0; c < FRAME; c++) begin
      tick();
      k = c / RD;
      chk({tag, "_an"}, 32'(an), 32'(4'hF & ~(4'b0001 << k)));
      chk({tag, "_led"}, 32'(LED), 32'(leds[7*k +: 7]));
      chk({tag, "_dp"}, 32'(dp_n), 32'(dpn[k]));
      if (c < FRAME - 1) chk({tag, "_pend"}, 32'(pending), 32'(exp_pend));
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    value = v; dp_in = dp; blank_in = bl; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  vec_t vecs[$];
  int   ft_count;
  int   cyc;

  initial begin
    vecs.push_back('{16'h12AF, 4'h0, 4'h0, {G1, G2, GA, GF}, 4'hF});
    vecs.push_back('{16'h8888, 4'b0001, 4'b0100, {G8, BL, G8, G8}, 4'b1110});
    vecs.push_back('{16'h3C9E, 4'b1010, 4'h0, {G3, GC, G9, GE}, 4'b0101});
    vecs.push_back('{16'h7654, 4'hF, 4'b1001, {BL, G6, G5, BL}, 4'b0000});
    vecs.push_back('{16'hBDE0, 4'h0, 4'h0, {GB, GD, GE, G0}, 4'hF});
`ifdef SEVSEG_LZB_EN
    vecs.push_back('{16'h0050, 4'h0, 4'h0, {BL, BL, G5, G0}, 4'hF});
    vecs.push_back('{16'h0000, 4'h0, 4'h0, {BL, BL, BL, G0}, 4'hF});
`else
    vecs.push_back('{16'h0050, 4'h0, 4'h0, {G0, G0, G5, G0}, 4'hF});
    vecs.push_back('{16'h0000, 4'h0, 4'h0, {G0, G0, G0, G0}, 4'hF});
`endif

    reset = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_in = '0;
    repeat (3) tick();
    chk("reset_led", 32'(LED), 32'(BL));
    chk("reset_an", 32'(an), 32'h0F);
    chk("reset_dp", 32'(dp_n), 32'h1);
    chk("reset_pend", 32'(pending), 32'h0);
    chk("reset_ft", 32'(frame_tick), 32'h0);

    // Free-running scan with all-zero active data.
    reset = 1'b1;
    ft_count = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk("scan_an", 32'(an), 32'(4'hF & ~(4'b0001 << (((i - 1) / RD) % D))));
      chk("scan_led", 32'(LED), 32'(G0));
      if (frame_tick === 1'b1) ft_count++;
    end
    chk("scan_ft_count", 32'(ft_count), 32'd2);

    // Table: load mid-frame, pending until boundary, then one clean frame.
    foreach (vecs[i]) begin
      wait_ft();
      repeat (3) tick();
      do_load(vecs[i].value, vecs[i].dp, vecs[i].blank);
      chk("vec_pend_set", 32'(pending), 32'h1);
      wait_ft();
      chk("vec_pend_clr", 32'(pending), 32'h0);
      check_frame("vec", vecs[i].leds, vecs[i].dpn, 1'b0);
    end

    // Two loads in one frame: the last one wins.
    wait_ft();
    tick();
    do_load(16'h1111, 4'h0, 4'h0);
    tick();
    do_load(16'h2222, 4'h0, 4'h0);
    wait_ft();
    check_frame("last_wins", {G2, G2, G2, G2}, 4'hF, 1'b0);

    // Load coincident with the boundary: old stage commits, new one waits a frame.
    wait_ft();
    cyc = 0;
    repeat (2) begin tick(); cyc++; end
    do_load(16'h4321, 4'h0, 4'h0);
    cyc++;
    while (cyc < FRAME - 1) begin tick(); cyc++; end
    value = 16'h9876; dp_in = 4'b0100; blank_in = '0; load = 1'b1;
    tick();
    load = 1'b0;
    chk("coinc_ft", 32'(frame_tick), 32'h1);
    chk("coinc_pend", 32'(pending), 32'h1);
    check_frame("coinc_old", {G4, G3, G2, G1}, 4'hF, 1'b1);
    chk("coinc_ft2", 32'(frame_tick), 32'h1);
    chk("coinc_pend2", 32'(pending), 32'h0);
    check_frame("coinc_new", {G9, G8, G7, G6}, 4'b1011, 1'b0);

    // Reset mid-frame abandons the scan and drops staged data.
    repeat (5) tick();
    do_load(16'h5555, 4'hF, 4'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_led", 32'(LED), 32'(BL));
    chk("mid_rst_an", 32'(an), 32'h0F);
    chk("mid_rst_dp", 32'(dp_n), 32'h1);
    chk("mid_rst_pend", 32'(pending), 32'h0);
    chk("mid_rst_ft", 32'(frame_tick), 32'h0);
    reset = 1'b1;
    tick();
    chk("post_rst_an", 32'(an), 32'h0E);
    chk("post_rst_led", 32'(LED), 32'(G0));
    wait_ft();
    check_frame("post_rst", {G0, G0, G0, G0}, 4'hF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised, time-multiplexed driver for a bank of common-anode 7-segment digits. It latches a packed hex word and scans it digit by digit at a programmable refresh rate, with per-digit blanking and decimal points. New values are taken only at frame boundaries, so the display never tears. It generalises the single-digit combinational hex decoder to N digits and adds scanning, staging and blanking. It sits between the datapath and the board's segment/anode pins.

## Interface
- DIGITS, 4: number of digits scanned; range 1..8.
- REFRESH_DIV, 50000: clk cycles each digit stays lit; must be ≥2.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- value  in  4*DIGITS  packed hex nibbles; nibble k = value[4k+3:4k] drives digit k (digit 0 rightmost).
- load  in  1  single-cycle strobe; stages value, dp_in and blank_in.
- dp_in  in  DIGITS  decimal-point enable per digit (1 = lit).
- blank_in  in  DIGITS  forced blank per digit (1 = all segments off).
- LED  out  7  segments, active-low; LED[6]=a … LED[0]=g.
- an  out  DIGITS  digit enables, active-low, one-hot-low while scanning.
- dp_n  out  1  decimal point, active-low.
- pending  out  1  staged data waiting for the next frame boundary.
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to 0.

## Operation
- Glyphs (active-low, a..g): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Divider counter div runs 0..REFRESH_DIV-1. At terminal count it returns to 0 and digit index idx advances. After DIGITS-1, idx wraps to 0.
- Stage/active registers: load copies value/dp_in/blank_in into the stage registers and sets pending.
  - A load while pending overwrites the stage; the last one wins.
- Frame boundary: a terminal count with idx=DIGITS-1.
  - If pending, the stage is copied into the active registers and pending clears.
  - frame_tick pulses in the same cycle.
- Load coincident with a frame boundary:
  - The old stage commits to active.
  - The new data is captured into the stage and pending remains 1.
- Display decode for digit idx:
  - an = ~(1<<idx).
  - LED = glyph of active nibble idx, or 1111111 if blanked.
  - dp_n = ~active_dp[idx]. A blanked digit still shows its dp.
- Reset clears div, idx, stage, active and pending to 0.
  - Outputs reset to LED=1111111, an=all 1, dp_n=1, frame_tick=0, pending=0.
  - Reset asserted mid-frame takes effect at the next edge and abandons the scan. Staged data is lost.

## Timing
- All outputs are registered and reflect idx/active with 1-cycle latency.
- First cycle after reset deasserts: outputs still at reset values.
- Next cycle: an=~1, digit 0 lit with active data, which is all zeros, so LED=0000001.
- Each digit stays lit for exactly REFRESH_DIV cycles; a full frame is DIGITS*REFRESH_DIV cycles.
- pending sets on the cycle after load. It clears on the cycle after the frame boundary.
- Committed data appears on the display one cycle after the boundary, together with digit 0.
- With DIGITS=1: every terminal count is a frame boundary and an is constantly 0 after reset.

## Configuration
- SEVSEG_LZB_EN defined: leading-zero blanking.
  - Digit k is also blanked when nibble k and every higher nibble of the active value are zero, for k>0.
  - Digit 0 is never blanked by this rule.
  - The blank mask is computed when data commits, so the decode path holds no extra logic.
- SEVSEG_LZB_EN undefined: only blank_in blanks digits; leading zeros display as "0".

## Test plan
- DIGITS=4, REFRESH_DIV=4: reset, then run 40 cycles.
  - an cycles through 1110,1101,1011,0111 for 4 cycles each.
  - LED=0000001 throughout.
  - frame_tick pulses every 16 cycles.
- Load value=16'h12AF mid-frame.
  - pending=1 until the boundary.
  - The next frame shows F,A,2,1 on digits 0..3: LED 0111000, 0001000, 0010010, 1001111.
- Two loads in one frame (16'h1111, then 16'h2222).
  - Only 2222 is ever displayed.
  - No frame ever shows a mix of the two values.
- Load coincident with the frame boundary.
  - The previously staged value commits.
  - The new value commits one frame later; pending stays high in between.
- blank_in=4'b0100, dp_in=4'b0001, value=16'h8888.
  - Digit 2: LED=1111111.
  - Digit 0: dp_n=0; other digits: dp_n=1.
- SEVSEG_LZB_EN on, value=16'h0050: digits 3 and 2 blanked, digit 1 shows 5, digit 0 shows 0. With value=16'h0000, only digit 0 shows 0.
- Reset asserted mid-frame: next cycle all outputs at reset values and pending=0.
